lfsr_rotating_arbiter: RTL and testbench

//  Parametrised queue arbiter for the MemorEDF scheduler. Picks one non-empty queue per grant.
//  The pick uses a run-time selectable policy: fixed, round-robin or Galois-LFSR-randomised rotation.
//  An age-based starvation guard overrides the policy. Grants leave through a registered valid/ready handshake.

---
 rtl/memoredf_arbiter_pkg.sv | 18 +
 rtl/rotated_priority_encoder.sv | 31 +++
 rtl/lfsr_rotating_arbiter.sv | 122 ++++++++++++
 tb/tb_lfsr_rotating_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/memoredf_arbiter_pkg.sv
// Shared types and helpers for the MemorEDF queue arbiter.
package memoredf_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_FIXED  = 2'd0,
        ARB_RR     = 2'd1,
        ARB_RANDOM = 2'd2
    } arb_mode_e;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'h8000;

    // Operates on a zero-extended 32-bit container; callers truncate back to their LFSR width.
    function automatic logic [31:0] galois_step(input logic [31:0] s, input logic [31:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 32'h0);
    endfunction

endpackage

// File: rtl/rotated_priority_encoder.sv
// Picks the first set request bit scanning upward from offset, wrapping modulo N.
module rotated_priority_encoder #(
    parameter int N = 4
) (
    input  logic [$clog2(N)-1:0] offset,
    input  logic [N-1:0]         request,
    output logic [$clog2(N)-1:0] index,
    output logic                 found
);

    localparam int W = $clog2(N);

    logic [W:0] pos;

    always_comb begin
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, offset} + (W + 1)'(k);
            if (pos >= (W + 1)'(N)) begin
                pos = pos - (W + 1)'(N);
            end
            if (!found && request[pos[W-1:0]]) begin
                found = 1'b1;
                index = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/lfsr_rotating_arbiter.sv
// Queue arbiter: fixed / round-robin / LFSR-rotated priority with an age-based starvation guard
// and a registered valid/ready grant output.
module lfsr_rotating_arbiter
    import memoredf_arbiter_pkg::*;
#(
    parameter int                     STATE_WIDTH      = 16,
    parameter logic [STATE_WIDTH-1:0] TAPS             = STATE_WIDTH'(DEFAULT_TAPS),
    parameter logic [STATE_WIDTH-1:0] SEED             = STATE_WIDTH'(DEFAULT_SEED),
    parameter int                     NUMBER_OF_QUEUES = 4,
    parameter int                     MAX_WAIT         = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUMBER_OF_QUEUES-1:0]         empty,
    input  logic [1:0]                          mode,
    input  logic                                seed_load,
    input  logic [STATE_WIDTH-1:0]              seed_value,
    output logic                                grant_valid,
    input  logic                                grant_ready,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0] grant_sel,
    output logic [STATE_WIDTH-1:0]              lfsr_state
);

    localparam int N     = NUMBER_OF_QUEUES;
    localparam int IDX_W = $clog2(N);
    localparam int AGE_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [IDX_W-1:0]       rr_offset, rr_next;
    logic [STATE_WIDTH-1:0] lfsr_next;
    logic [AGE_W-1:0]       age      [N];
    logic [AGE_W-1:0]       age_next [N];

    logic             handshake, load;
    logic [IDX_W-1:0] offset;
    logic [N-1:0]     starve_req;
    logic [IDX_W-1:0] pick_idx, starve_idx, pick;
    logic             pick_found, starve_found;

    always_comb begin
        handshake = grant_valid & grant_ready;
        load      = !grant_valid || handshake;

        lfsr_next = lfsr_state;
        if (seed_load) begin
            lfsr_next = (seed_value == '0) ? SEED : seed_value;
        end else if (handshake) begin
            lfsr_next = STATE_WIDTH'(galois_step(32'(lfsr_state), 32'(TAPS)));
        end

        rr_next = rr_offset;
        if (handshake) begin
            rr_next = (grant_sel == IDX_W'(N - 1)) ? '0 : grant_sel + IDX_W'(1);
        end

        for (int unsigned i = 0; i < N; i++) begin
            age_next[i] = age[i];
            if (handshake) begin
                if (empty[i] || grant_sel == IDX_W'(i)) begin
                    age_next[i] = '0;
                end else if (age[i] != AGE_W'(MAX_WAIT)) begin
                    age_next[i] = age[i] + AGE_W'(1);
                end
            end
        end

        // The pick sees state as it stands after this cycle's handshake, so the grant
        // being retired already counts as a bypass and the rotation has already advanced.
        starve_req = '0;
        for (int unsigned i = 0; i < N; i++) begin
            starve_req[i] = (MAX_WAIT != 0) && !empty[i] && (age_next[i] == AGE_W'(MAX_WAIT));
        end

        case (arb_mode_e'(mode))
            ARB_RR:     offset = rr_next;
            ARB_RANDOM: offset = IDX_W'(lfsr_next % STATE_WIDTH'(N));
            default:    offset = '0;
        endcase
    end

    rotated_priority_encoder #(.N(N)) u_policy_enc (
        .offset  (offset),
        .request (~empty),
        .index   (pick_idx),
        .found   (pick_found)
    );

    rotated_priority_encoder #(.N(N)) u_starve_enc (
        .offset  ('0),
        .request (starve_req),
        .index   (starve_idx),
        .found   (starve_found)
    );

    assign pick = starve_found ? starve_idx : pick_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_valid <= 1'b0;
            grant_sel   <= '0;
            lfsr_state  <= SEED;
            rr_offset   <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                age[i] <= '0;
            end
        end else begin
            lfsr_state <= lfsr_next;
            rr_offset  <= rr_next;
            for (int unsigned i = 0; i < N; i++) begin
                age[i] <= age_next[i];
            end
            if (load) begin
                if (pick_found) begin
                    grant_valid <= 1'b1;
                    grant_sel   <= pick;
                end else begin
                    grant_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rotating_arbiter.sv
// Directed bench for lfsr_rotating_arbiter (N=4, 16-bit LFSR, MAX_WAIT=3).
module tb_lfsr_rotating_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  empty = 4'hF;
    logic [1:0]  mode = 2'd0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_value = 16'h0;
    logic        grant_valid;
    logic        grant_ready = 1'b0;
    logic [1:0]  grant_sel;
    logic [15:0] lfsr_state;

    always #5 clock = ~clock;

    lfsr_rotating_arbiter #(
        .STATE_WIDTH      (16),
        .TAPS             (16'hB400),
        .SEED             (16'h8000),
        .NUMBER_OF_QUEUES (4),
        .MAX_WAIT         (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .empty       (empty),
        .mode        (mode),
        .seed_load   (seed_load),
        .seed_value  (seed_value),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_sel   (grant_sel),
        .lfsr_state  (lfsr_state)
    );

    typedef struct {
        logic [3:0] empty;
        logic [1:0] mode;
        logic       exp_valid;
        logic [1:0] exp_sel;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        empty       = 4'hF;
        mode        = 2'd0;
        seed_load   = 1'b0;
        seed_value  = 16'h0;
        grant_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0);
    endfunction

    vec_t vecs[10];
    logic [1:0]  rr_exp[6]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0]  starv_exp[6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] s;

    initial begin
        vecs[0] = '{4'b1111, 2'd0, 1'b0, 2'd0};
        vecs[1] = '{4'b0101, 2'd0, 1'b1, 2'd1};
        vecs[2] = '{4'b0000, 2'd0, 1'b1, 2'd0};
        vecs[3] = '{4'b1000, 2'd0, 1'b1, 2'd0};
        vecs[4] = '{4'b1110, 2'd1, 1'b1, 2'd0};
        vecs[5] = '{4'b0011, 2'd1, 1'b1, 2'd2};
        vecs[6] = '{4'b0110, 2'd2, 1'b1, 2'd0};
        vecs[7] = '{4'b1001, 2'd2, 1'b1, 2'd1};
        vecs[8] = '{4'b0111, 2'd3, 1'b1, 2'd3};
        vecs[9] = '{4'b0110, 2'd3, 1'b1, 2'd0};

        // Single-load picks from a clean reset.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            empty = vecs[i].empty;
            mode  = vecs[i].mode;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_sel", i), 32'(grant_sel), 32'(vecs[i].exp_sel));
        end

        // Idle after reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", 32'(grant_valid), 32'd0);
            check("idle_sel", 32'(grant_sel), 32'd0);
            check("idle_lfsr", 32'(lfsr_state), 32'h8000);
        end

        // Stall holds the grant through empty and mode changes.
        do_reset();
        empty = 4'b0101;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(grant_valid), 32'd1);
            check("stall_sel", 32'(grant_sel), 32'd1);
            tick();
        end
        empty = 4'b0000;
        mode  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_sel", 32'(grant_sel), 32'd1);
            check("stall_hold_lfsr", 32'(lfsr_state), 32'h8000);
        end
        grant_ready = 1'b1;
        tick();
        check("stall_release_sel", 32'(grant_sel), 32'd2);
        check("stall_release_lfsr", 32'(lfsr_state), 32'h4000);

        // LFSR stepping on consecutive handshakes.
        do_reset();
        empty       = 4'b1110;
        grant_ready = 1'b1;
        tick();
        s = 16'h8000;
        for (int k = 1; k <= 16; k++) begin
            tick();
            s = model_step(s);
            check($sformatf("lfsr_step%0d", k), 32'(lfsr_state), 32'(s));
            if (k == 1)  check("lfsr_after1", 32'(lfsr_state), 32'h4000);
            if (k == 15) check("lfsr_after15", 32'(lfsr_state), 32'h0001);
            if (k == 16) check("lfsr_after16", 32'(lfsr_state), 32'hB400);
        end

        // Round-robin rotation.
        do_reset();
        mode        = 2'd1;
        empty       = 4'b0000;
        grant_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr_valid%0d", i), 32'(grant_valid), 32'd1);
            check($sformatf("rr_sel%0d", i), 32'(grant_sel), 32'(rr_exp[i]));
        end

        // Starvation guard under fixed priority.
        do_reset();
        empty       = 4'b0000;
        grant_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("starve_sel%0d", i), 32'(grant_sel), 32'(starv_exp[i]));
        end

        // Seed loading, zero-seed fallback, random-mode pick, seed over step.
        do_reset();
        seed_load  = 1'b1;
        seed_value = 16'h00AA;
        tick();
        check("seed_aa", 32'(lfsr_state), 32'h00AA);
        seed_value = 16'h0000;
        tick();
        check("seed_zero", 32'(lfsr_state), 32'h8000);
        seed_value = 16'h0003;
        tick();
        seed_load = 1'b0;
        check("seed_3", 32'(lfsr_state), 32'h0003);
        empty = 4'b0000;
        mode  = 2'd2;
        tick();
        check("random_sel", 32'(grant_sel), 32'd3);
        grant_ready = 1'b1;
        tick();
        check("random_step", 32'(lfsr_state), 32'hB401);
        seed_load   = 1'b1;
        seed_value  = 16'h1234;
        tick();
        check("seed_over_step", 32'(lfsr_state), 32'h1234);
        seed_load   = 1'b0;
        grant_ready = 1'b0;
        tick();
        check("pre_reset_valid", 32'(grant_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_valid", 32'(grant_valid), 32'd0);
        check("async_reset_sel", 32'(grant_sel), 32'd0);
        check("async_reset_lfsr", 32'(lfsr_state), 32'h8000);
        tick();
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
